// File: rtl/adder_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | adder_pkg : shared types and defaults for the serial adder            |
// | Revision  : 1.0                                                       |
// +-----------------------------------------------------------------------+
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } serial_state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage : adder_pkg
`default_nettype wire

// File: rtl/bit_full_adder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bit_full_adder : one-bit full adder from two half adders              |
// | Revision       : 1.0                                                  |
// +-----------------------------------------------------------------------+
module half_adder (
    input  logic i_a,
    input  logic i_b,
    output logic o_sum,
    output logic o_carry
);
    assign o_sum   = i_a ^ i_b;
    assign o_carry = i_a & i_b;
endmodule : half_adder

module bit_full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_carry,
    output logic o_sum,
    output logic o_carry
);
    logic w_s1;
    logic w_c1;
    logic w_c2;

    half_adder u_ha0 (
        .i_a     (i_a),
        .i_b     (i_b),
        .o_sum   (w_s1),
        .o_carry (w_c1)
    );

    half_adder u_ha1 (
        .i_a     (w_s1),
        .i_b     (i_carry),
        .o_sum   (o_sum),
        .o_carry (w_c2)
    );

    assign o_carry = w_c1 | w_c2;
endmodule : bit_full_adder
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | serial_adder_ctrl : bit-serial adder sequencer, LSB first, one FA     |
// | Revision          : 1.0                                               |
// +-----------------------------------------------------------------------+
module serial_adder_ctrl
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_carry,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_busy
);
    localparam int            CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

    serial_state_t    r_state;
    serial_state_t    w_state_nxt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] w_a_shr;
    logic [WIDTH-1:0] w_b_shr;
    logic [WIDTH-1:0] w_sum_shr;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             w_fa_sum;
    logic             w_fa_carry;
    logic             w_accept;
    logic             w_last;

    bit_full_adder u_fa (
        .i_a     (r_a_sh[0]),
        .i_b     (r_b_sh[0]),
        .i_carry (r_carry),
        .o_sum   (w_fa_sum),
        .o_carry (w_fa_carry)
    );

    // New sum bits enter at the MSB so bit i lands in place after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_shift_w1
            assign w_a_shr   = '0;
            assign w_b_shr   = '0;
            assign w_sum_shr = w_fa_sum;
        end else begin : g_shift_wn
            assign w_a_shr   = {1'b0, r_a_sh[WIDTH-1:1]};
            assign w_b_shr   = {1'b0, r_b_sh[WIDTH-1:1]};
            assign w_sum_shr = {w_fa_sum, r_sum[WIDTH-1:1]};
        end
    endgenerate

    assign w_accept = i_valid && (r_state == IDLE);
    assign w_last   = (r_cnt == c_LAST);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = RUN;
            RUN:     if (w_last)   w_state_nxt = DONE;
            DONE:    if (i_ready)  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a_sh  <= i_a;
            r_b_sh  <= i_b;
            r_sum   <= '0;
            r_carry <= i_carry;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_a_sh  <= w_a_shr;
            r_b_sh  <= w_b_shr;
            r_sum   <= w_sum_shr;
            r_carry <= w_fa_carry;
            // Hold on the last bit so a power-of-two WIDTH never wraps the counter.
            if (!w_last) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_ready = (r_state == IDLE);
    assign o_busy  = (r_state == RUN);
    assign o_valid = (r_state == DONE);
    assign o_sum   = r_sum;
    assign o_carry = r_carry;

endmodule : serial_adder_ctrl
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_serial_adder_ctrl : directed + random checks of serial_adder_ctrl  |
// | Revision             : 1.0                                            |
// +-----------------------------------------------------------------------+
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_valid = 1'b0;
    logic         i_ready = 1'b0;
    logic [W-1:0] i_a = '0;
    logic [W-1:0] i_b = '0;
    logic         i_carry = 1'b0;
    logic         o_ready, o_valid, o_carry, o_busy;
    logic [W-1:0] o_sum;

    logic v1 = 1'b0, r1 = 1'b0, a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
    logic o_ready1, o_valid1, o_carry1, o_busy1;
    logic [0:0] o_sum1;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) u_dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_a(i_a), .i_b(i_b), .i_carry(i_carry), .o_valid(o_valid),
        .i_ready(i_ready), .o_sum(o_sum), .o_carry(o_carry), .o_busy(o_busy)
    );

    serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v1), .o_ready(o_ready1),
        .i_a(a1), .i_b(b1), .i_carry(c1), .o_valid(o_valid1),
        .i_ready(r1), .o_sum(o_sum1), .o_carry(o_carry1), .o_busy(o_busy1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Reference: plain (WIDTH+1)-bit addition, carry-out is the top bit.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [W:0] r;
        r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        return r;
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input int hold, input string tag);
        logic [W:0] e;
        int lat;
        int busy;
        e = model(a, b, c);
        check({tag, "_ready"}, 32'(o_ready), 32'd1);
        i_a = a; i_b = b; i_carry = c; i_valid = 1'b1; i_ready = 1'b0;
        step;
        i_valid = 1'b0;
        lat = 0;
        busy = 0;
        while (!o_valid && lat < 4 * W + 8) begin
            if (o_busy) busy++;
            i_valid = 1'($urandom);
            i_a = W'($urandom);
            step;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(W));
        check({tag, "_busy"}, 32'(busy), 32'(W));
        check({tag, "_result"}, 32'({o_carry, o_sum}), 32'(e));
        for (int h = 0; h < hold; h++) begin
            i_valid = 1'($urandom);
            step;
            check({tag, "_hold"}, 32'({o_valid, o_carry, o_sum}), 32'({1'b1, e}));
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        step;
        i_ready = 1'b0;
        check({tag, "_idle"}, 32'({o_ready, o_valid, o_busy}), 32'b100);
    endtask

    initial begin
        logic [W:0] e;
        logic [W:0] q[$];
        logic [1:0] e1;
        int got;
        int cyc;
        int last_acc;

        #12;
        check("reset8", 32'({o_ready, o_valid, o_busy, o_carry, o_sum}), 32'({4'b1000, 8'h00}));
        check("reset1", 32'({o_ready1, o_valid1, o_busy1, o_carry1, o_sum1}), 32'b10000);
        rst_n = 1'b1;
        step;

        run_op(8'h3C, 8'h42, 1'b0, 0, "t1");
        run_op(8'hFF, 8'h01, 1'b0, 0, "t2a");
        run_op(8'h5A, 8'hA5, 1'b1, 0, "t2b");
        run_op(8'h10, 8'h20, 1'b0, 5, "t3");
        for (int k = 0; k < 10; k++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)), "rnd");
        end

        // Reset in the middle of an add, with i_valid held high through it.
        i_a = 8'hAB; i_b = 8'hCD; i_carry = 1'b1; i_valid = 1'b1;
        step;
        i_valid = 1'b0;
        repeat (3) step;
        i_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check("t4_async", 32'({o_ready, o_valid, o_busy, o_carry, o_sum}), 32'({4'b1000, 8'h00}));
        step;
        check("t4_held", 32'({o_ready, o_valid, o_busy, o_sum}), 32'({3'b100, 8'h00}));
        i_valid = 1'b0;
        #3 rst_n = 1'b1;
        step;
        check("t4_release", 32'({o_ready, o_valid, o_busy}), 32'b100);
        run_op(8'h01, 8'h01, 1'b1, 0, "t4");

        for (int k = 0; k < 8; k++) begin
            a1 = k[0]; b1 = k[1]; c1 = k[2];
            e1 = 2'(a1) + 2'(b1) + 2'(c1);
            v1 = 1'b1;
            step;
            v1 = 1'b0;
            check("w1_busy", 32'({o_busy1, o_valid1}), 32'b10);
            step;
            check("w1_result", 32'({o_valid1, o_carry1, o_sum1}), 32'({1'b1, e1}));
            r1 = 1'b1;
            step;
            r1 = 1'b0;
            check("w1_idle", 32'(o_ready1), 32'd1);
        end

        got = 0;
        cyc = 0;
        last_acc = -1;
        i_valid = 1'b1;
        i_ready = 1'b1;
        while (got < 200 && cyc < 5000) begin
            if (o_ready) begin
                if (last_acc >= 0) check("t6_spacing", 32'(cyc - last_acc), 32'(W + 2));
                last_acc = cyc;
                i_a = W'($urandom); i_b = W'($urandom); i_carry = 1'($urandom);
                q.push_back(model(i_a, i_b, i_carry));
            end
            step;
            cyc++;
            if (o_valid) begin
                if (q.size() == 0) begin
                    check("t6_spurious", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("t6_result", 32'({o_carry, o_sum}), 32'(e));
                end
                got++;
            end
        end
        check("t6_count", 32'(got), 32'd200);
        i_valid = 1'b0;
        i_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule : tb_serial_adder_ctrl
`default_nettype wire
